// File: rtl/audio_stream_pkg.sv
// rtl/audio_stream_pkg.sv - shared types for the audio sample streamer
package audio_stream_pkg;

    typedef enum logic [1:0] {
        MODE_SILENCE = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_EXT     = 2'd3
    } mode_t;

    typedef enum logic {
        S_WAIT_READY  = 1'b0,
        S_WAIT_ACCEPT = 1'b1
    } state_t;

    // Smallest usable square period; shorter requests are stretched to this.
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO buffering external stereo samples
module sample_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    // Push into a full FIFO or pop from an empty one is silently ignored.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/audio_sample_streamer.sv
// rtl/audio_sample_streamer.sv - stereo sample source driving the codec write handshake
module audio_sample_streamer
    import audio_stream_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [SAMPLE_W-1:0] amplitude,
    input  logic [SAMPLE_W-1:0] step,
    input  logic                mute,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [SAMPLE_W-1:0] src_left,
    input  logic [SAMPLE_W-1:0] src_right,
    input  logic                write_ready,
    output logic                write_s,
    output logic [SAMPLE_W-1:0] writedata_left,
    output logic [SAMPLE_W-1:0] writedata_right,
    output logic [31:0]         sample_count
);

    localparam int FW = 2 * SAMPLE_W;

    state_t              r_state;
    mode_t               r_mode_prev;
    logic [PERIOD_W-1:0] r_cnt;
    logic [SAMPLE_W-1:0] r_ramp;

    mode_t               w_mode;
    logic                w_mode_chg;
    logic [PERIOD_W-1:0] w_period_eff;
    logic [PERIOD_W-1:0] w_cnt_cur;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic [PERIOD_W-1:0] w_cnt_next;
    logic [SAMPLE_W-1:0] w_ramp_cur;
    logic [SAMPLE_W-1:0] w_sq_level;
    logic [SAMPLE_W-1:0] w_gen_left;
    logic [SAMPLE_W-1:0] w_gen_right;
    logic                w_avail;
    logic                w_launch;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [FW-1:0]       w_fifo_head;

    assign w_mode     = mode_t'(mode);
    assign w_mode_chg = (w_mode != r_mode_prev);

    // A mode switch seen on the launch cycle already starts the generator from zero.
    assign w_period_eff = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
    assign w_cnt_cur    = (w_mode_chg || (r_cnt >= w_period_eff)) ? '0 : r_cnt;
    assign w_cnt_inc    = w_cnt_cur + PERIOD_W'(1);
    assign w_cnt_next   = (w_cnt_inc == w_period_eff) ? '0 : w_cnt_inc;
    assign w_ramp_cur   = w_mode_chg ? '0 : r_ramp;
    assign w_sq_level   = (w_cnt_cur < (w_period_eff >> 1)) ? -amplitude : amplitude;

    assign src_ready = !w_fifo_full && !reset;
    assign w_push    = src_valid && src_ready;
    assign w_avail   = (w_mode == MODE_EXT) ? !w_fifo_empty : 1'b1;
    assign w_launch  = (r_state == S_WAIT_READY) && write_ready && w_avail;
    assign w_pop     = w_launch && (w_mode == MODE_EXT);

    sample_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLOCK_50),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data ({src_left, src_right}),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    // Select the stereo pair offered at the next launch for the current mode.
    always_comb begin
        w_gen_left  = '0;
        w_gen_right = '0;
        case (w_mode)
            MODE_SQUARE: begin
                w_gen_left  = w_sq_level;
                w_gen_right = w_sq_level;
            end
            MODE_RAMP: begin
                w_gen_left  = w_ramp_cur;
                w_gen_right = w_ramp_cur;
            end
            MODE_EXT: begin
                w_gen_left  = w_fifo_head[FW-1:SAMPLE_W];
                w_gen_right = w_fifo_head[SAMPLE_W-1:0];
            end
            default: begin
                w_gen_left  = '0;
                w_gen_right = '0;
            end
        endcase
    end

    // Generator state: cleared on a mode change, advanced only when a sample launches.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_mode_prev <= MODE_SILENCE;
            r_cnt       <= '0;
            r_ramp      <= '0;
        end else begin
            r_mode_prev <= w_mode;
            if (w_mode_chg) begin
                r_cnt  <= '0;
                r_ramp <= '0;
            end
            if (w_launch && (w_mode == MODE_SQUARE)) begin
                r_cnt <= w_cnt_next;
            end
            if (w_launch && (w_mode == MODE_RAMP)) begin
                r_ramp <= w_ramp_cur + step;
            end
        end
    end

    // Codec handshake: launch on write_ready, hold until the codec drops write_ready.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state         <= S_WAIT_READY;
            write_s         <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            sample_count    <= '0;
        end else if (r_state == S_WAIT_READY) begin
            write_s <= 1'b0;
            if (w_launch) begin
                writedata_left  <= mute ? '0 : w_gen_left;
                writedata_right <= mute ? '0 : w_gen_right;
                write_s         <= 1'b1;
                r_state         <= S_WAIT_ACCEPT;
            end
        end else begin
            if (!write_ready) begin
                write_s      <= 1'b0;
                sample_count <= sample_count + 32'd1;
                r_state      <= S_WAIT_READY;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// tb/tb_audio_sample_streamer.sv - randomized self-checking bench for audio_sample_streamer
module tb_audio_sample_streamer;

    logic        CLOCK_50;
    logic        reset;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [15:0] amplitude;
    logic [15:0] step;
    logic        mute;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] src_left;
    logic [15:0] src_right;
    logic        write_ready;
    logic        write_s;
    logic [15:0] writedata_left;
    logic [15:0] writedata_right;
    logic [31:0] sample_count;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_count;
    logic [31:0] q[$];

    audio_sample_streamer #(
        .SAMPLE_W   (16),
        .PERIOD_W   (16),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .mode            (mode),
        .period          (period),
        .amplitude       (amplitude),
        .step            (step),
        .mute            (mute),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_left        (src_left),
        .src_right       (src_right),
        .write_ready     (write_ready),
        .write_s         (write_s),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .sample_count    (sample_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [15:0] sq_model(input int k, input int per, input logic [15:0] amp);
        int p;
        int v;
        p = (per < 2) ? 2 : per;
        v = ((k % p) < (p / 2)) ? -int'(amp) : int'(amp);
        return v[15:0];
    endfunction

    task automatic restart_mode(input logic [1:0] m);
        mode = 2'd0;
        tick();
        tick();
        mode = m;
        tick();
        tick();
    endtask

    // One full codec handshake; returns the launched pair.
    task automatic do_sample(output logic [15:0] l, output logic [15:0] r);
        int w;
        w = 0;
        write_ready = 1'b1;
        while (write_s !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (write_s !== 1'b1) begin
            n_errors++;
            $display("FAIL launch_timeout: write_s=%b required 1", write_s);
        end
        l = writedata_left;
        r = writedata_right;
        write_ready = 1'b0;
        tick();
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (write_s !== 1'b0 || sample_count !== exp_count) begin
            n_errors++;
            $display("FAIL accept: write_s=%b count=%0d required write_s=0 count=%0d",
                     write_s, sample_count, exp_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (write_s !== 1'b0 || writedata_left !== 16'h0 || writedata_right !== 16'h0 ||
            sample_count !== 32'd0 || src_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: ws=%b l=%h r=%h cnt=%0d rdy=%b required 0/0/0/0/0",
                     write_s, writedata_left, writedata_right, sample_count, src_ready);
        end
        reset = 1'b0;
        exp_count = 0;
        tick();
        n_checks++;
        if (src_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: src_ready=%b required 1", src_ready);
        end
    endtask

    task automatic test_square();
        int pers [4];
        int nsmp [4];
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] e;
        pers = '{182, 1, 7, 0};
        nsmp = '{192, 6, 15, 5};
        for (int t = 0; t < 4; t++) begin
            period    = 16'(pers[t]);
            amplitude = (t == 0) ? 16'd256 : 16'($urandom);
            restart_mode(2'd1);
            for (int k = 0; k < nsmp[t]; k++) begin
                do_sample(l, r);
                e = sq_model(k, pers[t], amplitude);
                n_checks++;
                if (l !== e || r !== e) begin
                    n_errors++;
                    $display("FAIL square p=%0d k=%0d: got L=%h R=%h required %h",
                             pers[t], k, l, r, e);
                end
            end
        end
    endtask

    task automatic test_hold();
        int w;
        logic [15:0] dl;
        logic [15:0] dr;
        w = 0;
        write_ready = 1'b1;
        while (write_s !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (write_s !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_launch: write_s=%b required 1", write_s);
        end
        dl = writedata_left;
        dr = writedata_right;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (write_s !== 1'b1 || writedata_left !== dl || writedata_right !== dr) begin
                n_errors++;
                $display("FAIL hold_stable cyc=%0d: ws=%b L=%h R=%h required 1 %h %h",
                         i, write_s, writedata_left, writedata_right, dl, dr);
            end
        end
        write_ready = 1'b0;
        tick();
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (write_s !== 1'b0 || sample_count !== exp_count) begin
            n_errors++;
            $display("FAIL hold_release: ws=%b count=%0d required 0 %0d",
                     write_s, sample_count, exp_count);
        end
    endtask

    task automatic test_ramp();
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] e;
        for (int t = 0; t < 2; t++) begin
            step = (t == 0) ? 16'h4000 : 16'($urandom);
            restart_mode(2'd2);
            for (int k = 0; k < 6; k++) begin
                do_sample(l, r);
                e = 16'(k * int'(step));
                n_checks++;
                if (l !== e || r !== e) begin
                    n_errors++;
                    $display("FAIL ramp step=%h k=%0d: got L=%h R=%h required %h",
                             step, k, l, r, e);
                end
            end
        end
    endtask

    task automatic test_mute();
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] e;
        period    = 16'd8;
        amplitude = 16'h1234;
        restart_mode(2'd1);
        mute = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mute = 1'b0;
            do_sample(l, r);
            e = (k < 3) ? 16'h0000 : sq_model(k, 8, 16'h1234);
            n_checks++;
            if (l !== e || r !== e) begin
                n_errors++;
                $display("FAIL mute k=%0d: got L=%h R=%h required %h", k, l, r, e);
            end
        end
    endtask

    task automatic test_ext();
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] e;
        logic        exp_rdy;
        restart_mode(2'd3);
        write_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            src_left  = 16'($urandom);
            src_right = ~src_left;
            src_valid = 1'b1;
            exp_rdy   = (q.size() < 4);
            n_checks++;
            if (src_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL ext_ready push=%0d: src_ready=%b required %b", i, src_ready, exp_rdy);
            end
            if (exp_rdy) q.push_back({src_left, src_right});
            tick();
        end
        src_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_sample(l, r);
            e = q.pop_front();
            n_checks++;
            if ({l, r} !== e) begin
                n_errors++;
                $display("FAIL ext_order k=%0d: got %h required %h", k, {l, r}, e);
            end
        end
        write_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (write_s !== 1'b0) begin
                n_errors++;
                $display("FAIL ext_stall cyc=%0d: write_s=%b required 0", i, write_s);
            end
        end
        write_ready = 1'b0;
        tick();
    endtask

    // Random producer and codec timing against a queue model of the FIFO and handshake.
    task automatic test_back_to_back();
        logic        push_now;
        logic        prev_ws;
        logic        exp_ws;
        logic [31:0] pdata;
        logic [31:0] e;
        q.delete();
        for (int i = 0; i < 300; i++) begin
            if (i < 295) begin
                src_valid   = 1'($urandom_range(0, 1));
                src_left    = 16'($urandom);
                src_right   = 16'($urandom);
                write_ready = 1'($urandom_range(0, 1));
            end else begin
                src_valid   = 1'b0;
                write_ready = 1'b0;
            end
            n_checks++;
            if (src_ready !== (q.size() < 4)) begin
                n_errors++;
                $display("FAIL b2b_ready cyc=%0d: src_ready=%b required %b", i, src_ready, q.size() < 4);
            end
            push_now = src_valid && (q.size() < 4);
            pdata    = {src_left, src_right};
            prev_ws  = write_s;
            exp_ws   = prev_ws ? write_ready : (write_ready && q.size() > 0);
            tick();
            n_checks++;
            if (write_s !== exp_ws) begin
                n_errors++;
                $display("FAIL b2b_strobe cyc=%0d: write_s=%b required %b", i, write_s, exp_ws);
            end
            if (!prev_ws && write_s && q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({writedata_left, writedata_right} !== e) begin
                    n_errors++;
                    $display("FAIL b2b_data cyc=%0d: got %h required %h",
                             i, {writedata_left, writedata_right}, e);
                end
            end
            if (prev_ws && !write_s) exp_count = exp_count + 32'd1;
            if (push_now) q.push_back(pdata);
        end
        n_checks++;
        if (sample_count !== exp_count) begin
            n_errors++;
            $display("FAIL b2b_count: sample_count=%0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        src_valid = 1'b1;
        src_left  = 16'h1111;
        src_right = 16'h2222;
        tick();
        tick();
        src_valid = 1'b0;
        restart_mode(2'd1);
        w = 0;
        write_ready = 1'b1;
        while (write_s !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (write_s !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_launch: write_s=%b required 1", write_s);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (write_s !== 1'b0 || sample_count !== 32'd0 || writedata_left !== 16'h0 ||
            src_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_reset: ws=%b cnt=%0d L=%h rdy=%b required 0 0 0000 0",
                     write_s, sample_count, writedata_left, src_ready);
        end
        reset = 1'b0;
        exp_count = 0;
        write_ready = 1'b0;
        mode = 2'd3;
        tick();
        n_checks++;
        if (src_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_ready: src_ready=%b required 1", src_ready);
        end
        write_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (write_s !== 1'b0) begin
                n_errors++;
                $display("FAIL rmid_fifo_empty cyc=%0d: write_s=%b required 0", i, write_s);
            end
        end
        write_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_count   = 0;
        reset       = 1'b1;
        mode        = 2'd0;
        period      = 16'd2;
        amplitude   = 16'd0;
        step        = 16'd0;
        mute        = 1'b0;
        src_valid   = 1'b0;
        src_left    = 16'd0;
        src_right   = 16'd0;
        write_ready = 1'b0;
        test_reset();
        test_square();
        test_hold();
        test_ramp();
        test_mute();
        test_ext();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
